hmc_rf_master: RTL and testbench

- Register-file initiator for the openHMC controller's RF port (rf_address/rf_read_en/rf_write_en/rf_write_data in; rf_read_data/rf_invalid_address/rf_access_complete out of the controller).
- Accepts single commands (read, write, poll-until-match) on a valid/ready command port and drives the RF access protocol.
- Returns one response per command with data and status.
- Used by the bring-up sequencer and by bench tests that need realistic RF traffic.

---
 rtl/hmc_rf_master_if.sv | 51 +++++
 rtl/hmc_rf_master.sv | 188 ++++++++++++++++++
 tb/tb_hmc_rf_master.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hmc_rf_master_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : hmc_rf_master_if
// Purpose  : Command/response port and openHMC RF access port of the RF
//            initiator, bundled with a view for each side.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface hmc_rf_master_if #(
   parameter int HMC_RF_AWIDTH = 4,
   parameter int HMC_RF_WWIDTH = 64,
   parameter int HMC_RF_RWIDTH = 64
);
   // command port
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [1:0]               cmd_op;
   logic [HMC_RF_AWIDTH-1:0] cmd_addr;
   logic [HMC_RF_WWIDTH-1:0] cmd_wdata;
   logic [HMC_RF_RWIDTH-1:0] cmd_mask;
   // response port
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [HMC_RF_RWIDTH-1:0] rsp_rdata;
   logic [2:0]               rsp_status;
   logic                     busy;
   // controller RF port
   logic [HMC_RF_AWIDTH-1:0] rf_address;
   logic                     rf_read_en;
   logic                     rf_write_en;
   logic [HMC_RF_WWIDTH-1:0] rf_write_data;
   logic [HMC_RF_RWIDTH-1:0] rf_read_data;
   logic                     rf_invalid_address;
   logic                     rf_access_complete;

   // the RF initiator itself
   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready,
             rf_read_data, rf_invalid_address, rf_access_complete,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_status, busy,
             rf_address, rf_read_en, rf_write_en, rf_write_data
   );

   // command issuer plus RF responder
   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready,
             rf_read_data, rf_invalid_address, rf_access_complete,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_status, busy,
             rf_address, rf_read_en, rf_write_en, rf_write_data
   );
endinterface
`default_nettype wire

// File: rtl/hmc_rf_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : hmc_rf_master
// Purpose  : Register-file initiator for the openHMC RF port. Executes one
//            read, write or poll-until-match command at a time and returns a
//            single response carrying data and status.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module hmc_rf_master #(
   parameter int HMC_RF_AWIDTH = 4,
   parameter int HMC_RF_WWIDTH = 64,
   parameter int HMC_RF_RWIDTH = 64,
   parameter int TIMEOUT_LOG   = 8,
   parameter int POLL_MAX_LOG  = 10
) (
   input  logic              clk_hmc,
   input  logic              res_n_hmc,
   hmc_rf_master_if.master   bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_GAP   = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   localparam logic [1:0] c_op_read    = 2'b00;
   localparam logic [1:0] c_op_write   = 2'b01;
   localparam logic [1:0] c_op_illegal = 2'b11;

   localparam logic [2:0] c_st_ok      = 3'd0;
   localparam logic [2:0] c_st_invalid = 3'd1;
   localparam logic [2:0] c_st_timeout = 3'd2;
   localparam logic [2:0] c_st_pollfail= 3'd3;
   localparam logic [2:0] c_st_illegal = 3'd4;

   // timeout fires on the WAIT cycle whose incremented count hits all-ones
   localparam logic [TIMEOUT_LOG-1:0] c_tmo_last   = '1;
   localparam logic [POLL_MAX_LOG:0]  c_poll_limit = {1'b1, {POLL_MAX_LOG{1'b0}}};

   state_t                   r_state;
   logic [1:0]               r_op;
   logic [HMC_RF_AWIDTH-1:0] r_addr;
   logic [HMC_RF_WWIDTH-1:0] r_wdata;
   logic [HMC_RF_RWIDTH-1:0] r_mask;
   logic [TIMEOUT_LOG-1:0]   r_tmo;
   logic [POLL_MAX_LOG:0]    r_poll;

   logic [TIMEOUT_LOG-1:0]   w_tmo_next;
   logic [POLL_MAX_LOG:0]    w_poll_next;
   logic                     w_match;
   logic                     w_done;
   logic [2:0]               w_status;
   logic [HMC_RF_RWIDTH-1:0] w_rdata;

   // WAIT-state outcome: completion beats the terminal timeout count
   always_comb begin
      w_tmo_next  = r_tmo + 1'b1;
      w_poll_next = r_poll + 1'b1;
      w_match     = ((bus.rf_read_data ^ HMC_RF_RWIDTH'(r_wdata)) & r_mask) == '0;
      w_done      = 1'b0;
      w_status    = c_st_ok;
      w_rdata     = '0;
      if (bus.rf_access_complete) begin
         if (bus.rf_invalid_address) begin
            w_done   = 1'b1;
            w_status = c_st_invalid;
         end else begin
            case (r_op)
               c_op_read: begin
                  w_done  = 1'b1;
                  w_rdata = bus.rf_read_data;
               end
               c_op_write: begin
                  w_done  = 1'b1;
               end
               default: begin
                  if (w_match) begin
                     w_done  = 1'b1;
                     w_rdata = bus.rf_read_data;
                  end else if (w_poll_next == c_poll_limit) begin
                     w_done   = 1'b1;
                     w_status = c_st_pollfail;
                     w_rdata  = bus.rf_read_data;
                  end
               end
            endcase
         end
      end else if (w_tmo_next == c_tmo_last) begin
         w_done   = 1'b1;
         w_status = c_st_timeout;
      end
   end

   // command FSM with all port outputs registered
   always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
      if (!res_n_hmc) begin
         r_state           <= ST_IDLE;
         r_op              <= '0;
         r_addr            <= '0;
         r_wdata           <= '0;
         r_mask            <= '0;
         r_tmo             <= '0;
         r_poll            <= '0;
         bus.cmd_ready     <= 1'b1;
         bus.rsp_valid     <= 1'b0;
         bus.rsp_rdata     <= '0;
         bus.rsp_status    <= '0;
         bus.busy          <= 1'b0;
         bus.rf_address    <= '0;
         bus.rf_read_en    <= 1'b0;
         bus.rf_write_en   <= 1'b0;
         bus.rf_write_data <= '0;
      end else begin
         // strobes are single-cycle unless re-asserted below
         bus.rf_read_en  <= 1'b0;
         bus.rf_write_en <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  r_op          <= bus.cmd_op;
                  r_addr        <= bus.cmd_addr;
                  r_wdata       <= bus.cmd_wdata;
                  r_mask        <= bus.cmd_mask;
                  r_poll        <= '0;
                  bus.cmd_ready <= 1'b0;
                  bus.busy      <= 1'b1;
                  if (bus.cmd_op == c_op_illegal) begin
                     r_state        <= ST_RESP;
                     bus.rsp_valid  <= 1'b1;
                     bus.rsp_status <= c_st_illegal;
                     bus.rsp_rdata  <= '0;
                  end else begin
                     r_state           <= ST_ISSUE;
                     bus.rf_address    <= bus.cmd_addr;
                     bus.rf_read_en    <= (bus.cmd_op != c_op_write);
                     bus.rf_write_en   <= (bus.cmd_op == c_op_write);
                     bus.rf_write_data <= (bus.cmd_op == c_op_write) ? bus.cmd_wdata : '0;
                  end
               end
            end
            ST_ISSUE: begin
               // a complete seen here coincides with the strobe and is ignored
               r_tmo   <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_done) begin
                  r_state        <= ST_RESP;
                  bus.rsp_valid  <= 1'b1;
                  bus.rsp_status <= w_status;
                  bus.rsp_rdata  <= w_rdata;
               end else begin
                  r_tmo <= w_tmo_next;
                  if (bus.rf_access_complete) begin
                     r_poll  <= w_poll_next;
                     r_state <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               r_state        <= ST_ISSUE;
               bus.rf_address <= r_addr;
               bus.rf_read_en <= 1'b1;
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  r_state           <= ST_IDLE;
                  bus.rsp_valid     <= 1'b0;
                  bus.rsp_rdata     <= '0;
                  bus.rsp_status    <= '0;
                  bus.busy          <= 1'b0;
                  bus.cmd_ready     <= 1'b1;
                  bus.rf_address    <= '0;
                  bus.rf_write_data <= '0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hmc_rf_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_hmc_rf_master
// Purpose  : Self-checking bench for hmc_rf_master: RF responder model,
//            response scoreboard, vector table and multi-cycle sequences.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_hmc_rf_master;

   localparam int AW   = 4;
   localparam int WW   = 64;
   localparam int RW   = 64;
   localparam int TLOG = 4;
   localparam int PLOG = 2;

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  addr;
      logic [63:0] wdata;
      logic [63:0] mask;
      int          dly;
      logic [63:0] rd;
      logic        inv;
      logic [63:0] exp_rd;
      logic [2:0]  exp_st;
      int          exp_strb;
      int          exp_lat;
   } vec_t;

   typedef struct {
      int          dly;
      logic [63:0] data;
      logic        inv;
   } rq_t;

   typedef struct {
      logic [63:0] rd;
      logic [2:0]  st;
   } ex_t;

   logic clk   = 1'b0;
   logic res_n = 1'b0;
   always #5 clk = ~clk;

   hmc_rf_master_if #(.HMC_RF_AWIDTH(AW), .HMC_RF_WWIDTH(WW), .HMC_RF_RWIDTH(RW)) bus ();

   hmc_rf_master #(
      .HMC_RF_AWIDTH(AW), .HMC_RF_WWIDTH(WW), .HMC_RF_RWIDTH(RW),
      .TIMEOUT_LOG(TLOG), .POLL_MAX_LOG(PLOG)
   ) dut (
      .clk_hmc   (clk),
      .res_n_hmc (res_n),
      .bus       (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- RF responder ----------------
   logic        resp_cpl  = 1'b0;
   logic        force_cpl = 1'b0;
   logic        resp_inv  = 1'b0;
   logic [63:0] resp_data = '0;
   rq_t         rq[$];

   assign bus.rf_access_complete = resp_cpl | force_cpl;
   assign bus.rf_read_data       = resp_data;
   assign bus.rf_invalid_address = resp_inv;

   initial begin
      rq_t e;
      forever begin
         @(posedge clk); #1;
         if (res_n && (bus.rf_read_en || bus.rf_write_en) && rq.size() > 0) begin
            e = rq.pop_front();
            repeat (e.dly) begin @(posedge clk); #1; end
            resp_cpl  = 1'b1;
            resp_data = e.data;
            resp_inv  = e.inv;
            @(posedge clk); #1;
            resp_cpl  = 1'b0;
            resp_data = '0;
            resp_inv  = 1'b0;
         end
      end
   end

   // ---------------- monitor + scoreboard ----------------
   ex_t         exq[$];
   int          n_rd = 0;
   int          n_wr = 0;
   logic [63:0] last_wd = '0;
   int          strb_cyc[$];
   int          rsp_start = 0;
   logic        prev_valid = 1'b0;

   always @(negedge clk) begin
      ex_t e;
      if (bus.rf_read_en || bus.rf_write_en) begin
         chk("excl_strobe", {63'd0, bus.rf_read_en & bus.rf_write_en}, 64'd0);
         strb_cyc.push_back(cyc);
         if (bus.rf_read_en) n_rd++;
         if (bus.rf_write_en) begin
            n_wr++;
            last_wd = bus.rf_write_data;
         end
      end
      if (bus.rsp_valid && !prev_valid) rsp_start = cyc;
      prev_valid = bus.rsp_valid;
      if (bus.rsp_valid && bus.rsp_ready) begin
         if (exq.size() == 0) begin
            chk("unexpected_rsp", 64'd1, 64'd0);
         end else begin
            e = exq.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, e.rd);
            chk("rsp_status", 64'(bus.rsp_status), 64'(e.st));
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic send(input logic [1:0] op, input logic [3:0] addr,
                       input logic [63:0] wd, input logic [63:0] mask, output int acc);
      int k = 0;
      @(posedge clk); #1;
      while (!bus.cmd_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      chk("cmd_ready_wait", {63'd0, bus.cmd_ready}, 64'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wd;
      bus.cmd_mask  = mask;
      acc = cyc;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.cmd_mask  = '0;
   endtask

   task automatic wait_done();
      int k = 0;
      @(posedge clk); #2;
      while ((exq.size() != 0 || bus.busy) && k < 100) begin
         @(posedge clk); #2;
         k++;
      end
      chk("rsp_wait", {63'd0, (exq.size() == 0 && !bus.busy)}, 64'd1);
   endtask

   vec_t vt[10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   acc;
      int   b_rd;
      int   b_wr;
      int   b_s;
      logic flag;
      vec_t v;

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.cmd_mask  = '0;
      bus.rsp_ready = 1'b1;

      //        op     addr   wdata      mask     dly rd                      inv   exp_rd                  st    strb lat
      vt[0] = '{2'd0, 4'h2, 64'd0,     64'd0,     1, 64'hDEAD_BEEF_0000_0001, 1'b0, 64'hDEAD_BEEF_0000_0001, 3'd0, 1,  3};
      vt[1] = '{2'd1, 4'h0, 64'h5,     64'd0,     3, 64'd0,                  1'b0, 64'd0,                  3'd0, 1,  5};
      vt[2] = '{2'd0, 4'h7, 64'd0,     64'd0,     2, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0123_4567_89AB_CDEF, 3'd0, 1,  4};
      vt[3] = '{2'd0, 4'h3, 64'd0,     64'd0,     1, 64'h1111,               1'b1, 64'd0,                  3'd1, 1,  3};
      vt[4] = '{2'd1, 4'hF, 64'hAAAA,  64'd0,     1, 64'd0,                  1'b1, 64'd0,                  3'd1, 1,  3};
      vt[5] = '{2'd2, 4'h1, 64'hF0,    64'hFF,    1, 64'h12F0,               1'b0, 64'h12F0,               3'd0, 1,  3};
      vt[6] = '{2'd0, 4'h4, 64'd0,     64'd0,    15, 64'h77,                 1'b0, 64'h77,                 3'd0, 1, 17};
      vt[7] = '{2'd3, 4'h6, 64'h9,     64'd0,     1, 64'd0,                  1'b0, 64'd0,                  3'd4, 0,  1};
      vt[8] = '{2'd2, 4'h8, 64'h1,     64'h1,     1, 64'h1,                  1'b1, 64'd0,                  3'd1, 1,  3};
      vt[9] = '{2'd0, 4'h9, 64'd0,     64'd0,     0, 64'h55,                 1'b0, 64'd0,                  3'd2, 1, 17};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", {60'd0, bus.rsp_valid, bus.busy, bus.rf_read_en, bus.rf_write_en}, 64'd0);
      chk("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
      chk("rst_rsp", bus.rsp_rdata | 64'(bus.rsp_status), 64'd0);
      chk("rst_rf", bus.rf_write_data | 64'(bus.rf_address), 64'd0);
      res_n = 1'b1;

      // single-access vectors
      for (int i = 0; i < 10; i++) begin
         v    = vt[i];
         b_rd = n_rd;
         b_wr = n_wr;
         if (v.op != 2'd3) rq.push_back('{v.dly, v.rd, v.inv});
         exq.push_back('{v.exp_rd, v.exp_st});
         send(v.op, v.addr, v.wdata, v.mask, acc);
         wait_done();
         chk($sformatf("v%0d_strobes", i), 64'((n_rd - b_rd) + (n_wr - b_wr)), 64'(v.exp_strb));
         chk($sformatf("v%0d_latency", i), 64'(rsp_start - acc), 64'(v.exp_lat));
         if (v.op != 2'd3)
            chk($sformatf("v%0d_wr_strobe", i), 64'(n_wr - b_wr), {63'd0, v.op == 2'd1});
         if (v.op == 2'd1)
            chk($sformatf("v%0d_wr_data", i), last_wd, v.wdata);
      end

      // write held in RESP by a stalled consumer
      bus.rsp_ready = 1'b0;
      rq.push_back('{3, 64'd0, 1'b0});
      exq.push_back('{64'd0, 3'd0});
      send(2'd1, 4'h0, 64'h5, 64'd0, acc);
      b_s = 0;
      while (!bus.rsp_valid && b_s < 40) begin
         @(posedge clk); #1;
         b_s++;
      end
      repeat (3) begin
         @(posedge clk); #1;
         chk("stall_hold", {60'd0, bus.rsp_valid, bus.busy, bus.cmd_ready, 1'b0}, 64'b1100);
         chk("stall_status", 64'(bus.rsp_status), 64'd0);
      end
      bus.rsp_ready = 1'b1;
      wait_done();

      // poll matching on the third read
      b_rd = n_rd;
      b_s  = strb_cyc.size();
      rq.push_back('{1, 64'd0, 1'b0});
      rq.push_back('{1, 64'd0, 1'b0});
      rq.push_back('{1, 64'd1, 1'b0});
      exq.push_back('{64'd1, 3'd0});
      send(2'd2, 4'h1, 64'h1, 64'h1, acc);
      wait_done();
      chk("poll_reads", 64'(n_rd - b_rd), 64'd3);
      flag = (strb_cyc.size() == b_s + 3) &&
             (strb_cyc[b_s+1] - strb_cyc[b_s] >= 2) &&
             (strb_cyc[b_s+2] - strb_cyc[b_s+1] >= 2);
      chk("poll_gap", {63'd0, flag}, 64'd1);

      // poll never matching gives up after 2^POLL_MAX_LOG reads
      b_rd = n_rd;
      rq.push_back('{1, 64'd2, 1'b0});
      rq.push_back('{1, 64'd4, 1'b0});
      rq.push_back('{1, 64'd6, 1'b0});
      rq.push_back('{1, 64'd8, 1'b0});
      exq.push_back('{64'd8, 3'd3});
      send(2'd2, 4'h1, 64'h1, 64'h1, acc);
      wait_done();
      chk("pollfail_reads", 64'(n_rd - b_rd), 64'd4);

      // timeout, then a stray late complete, then a normal read
      exq.push_back('{64'd0, 3'd2});
      send(2'd0, 4'hA, 64'd0, 64'd0, acc);
      wait_done();
      chk("tmo_latency", 64'(rsp_start - acc), 64'd17);
      @(posedge clk); #1;
      force_cpl = 1'b1;
      @(posedge clk); #1;
      force_cpl = 1'b0;
      flag = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         flag = flag | bus.rsp_valid | bus.busy | !bus.cmd_ready;
      end
      chk("late_cpl_ignored", {63'd0, flag}, 64'd0);
      rq.push_back('{2, 64'hCAFE, 1'b0});
      exq.push_back('{64'hCAFE, 3'd0});
      send(2'd0, 4'hB, 64'd0, 64'd0, acc);
      wait_done();
      chk("after_tmo_latency", 64'(rsp_start - acc), 64'd4);

      // reset in the middle of WAIT abandons the access
      rq.push_back('{10, 64'h99, 1'b0});
      send(2'd0, 4'h5, 64'd0, 64'd0, acc);
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
      res_n = 1'b0;
      #1;
      chk("mid_rst_ctrl", {61'd0, bus.rsp_valid, bus.busy, bus.rf_read_en}, 64'd0);
      chk("mid_rst_rf", bus.rf_write_data | 64'(bus.rf_address) | bus.rsp_rdata, 64'd0);
      @(posedge clk); #1;
      res_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", {63'd0, bus.cmd_ready}, 64'd1);
      b_rd = n_rd;
      flag = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         flag = flag | bus.rsp_valid | bus.busy;
      end
      chk("post_rst_quiet", {63'd0, flag}, 64'd0);
      chk("post_rst_no_strobe", 64'(n_rd - b_rd), 64'd0);
      rq.push_back('{1, 64'h1234, 1'b0});
      exq.push_back('{64'h1234, 3'd0});
      send(2'd0, 4'h2, 64'd0, 64'd0, acc);
      wait_done();
      chk("post_rst_latency", 64'(rsp_start - acc), 64'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
